// File: rtl/dma_csr_multi.sv
// Multi-channel DMA control/status register block with an Avalon-MM slave port.
// Each channel owns RDADDR/WRADDR/LENGTH/CONTROL/STATUS registers and a
// two-state IDLE/BUSY sequencer that launches and retires one transfer at a time.
module dma_csr_multi #(
    parameter  int NUM_CH  = 4,
    parameter  int LEN_W   = 24,
    localparam int CH_BITS = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    iClk,
    input  logic                    iReset_n,
    input  logic                    iChipselect,
    input  logic                    iRead,
    input  logic                    iWrite,
    input  logic [CH_BITS+2:0]      iAddress,
    input  logic [31:0]             iWritedata,
    output logic [31:0]             oReaddata,
    output logic                    oIrq,
    output logic [NUM_CH*32-1:0]    oRM_startaddress,
    output logic [NUM_CH*32-1:0]    oWM_startaddress,
    output logic [NUM_CH*LEN_W-1:0] oLength,
    output logic [NUM_CH-1:0]       oStart,
    output logic [NUM_CH-1:0]       oAbort,
    input  logic [NUM_CH-1:0]       iWM_done,
    input  logic [NUM_CH-1:0]       iError
);

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    localparam logic [2:0] REG_RDADDR  = 3'd0;
    localparam logic [2:0] REG_WRADDR  = 3'd1;
    localparam logic [2:0] REG_LENGTH  = 3'd2;
    localparam logic [2:0] REG_CONTROL = 3'd3;
    localparam logic [2:0] REG_STATUS  = 3'd4;

    state_t             state_q  [NUM_CH];
    logic [31:0]        rdaddr_q [NUM_CH];
    logic [31:0]        wraddr_q [NUM_CH];
    logic [LEN_W-1:0]   len_q    [NUM_CH];
    logic [NUM_CH-1:0]  ie_q;
    logic [NUM_CH-1:0]  done_q;
    logic [NUM_CH-1:0]  err_q;
    logic [NUM_CH-1:0]  abt_q;

    logic [CH_BITS-1:0] acc_ch;
    logic [2:0]         acc_reg;
    logic [NUM_CH-1:0]  wr_sel;
    logic [31:0]        rd_mux;

    // Split the word address and decode which channel (if any) a write targets
    always_comb begin
        acc_ch  = iAddress[CH_BITS+2:3];
        acc_reg = iAddress[2:0];
        wr_sel  = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            wr_sel[n] = iChipselect & iWrite & (acc_ch == CH_BITS'(n));
        end
    end

    // Read multiplexer; channels beyond NUM_CH never match and read 0
    always_comb begin
        rd_mux = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            if (acc_ch == CH_BITS'(n)) begin
                case (acc_reg)
                    REG_RDADDR:  rd_mux = rdaddr_q[n];
                    REG_WRADDR:  rd_mux = wraddr_q[n];
                    REG_LENGTH:  rd_mux[LEN_W-1:0] = len_q[n];
                    REG_CONTROL: rd_mux[1] = ie_q[n];
                    REG_STATUS:  rd_mux[3:0] = {abt_q[n], err_q[n], (state_q[n] == ST_BUSY), done_q[n]};
                    default:     rd_mux = '0;
                endcase
            end
        end
    end

    // Pack per-channel programming registers onto the flat master-facing buses
    always_comb begin
        oRM_startaddress = '0;
        oWM_startaddress = '0;
        oLength          = '0;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
            oRM_startaddress[32*n +: 32]       = rdaddr_q[n];
            oWM_startaddress[32*n +: 32]       = wraddr_q[n];
            oLength[LEN_W*n +: LEN_W]          = len_q[n];
        end
    end

    // Register writes, W1C and the per-channel IDLE/BUSY sequencers
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oStart <= '0;
            oAbort <= '0;
            ie_q   <= '0;
            done_q <= '0;
            err_q  <= '0;
            abt_q  <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                state_q[n]  <= ST_IDLE;
                rdaddr_q[n] <= '0;
                wraddr_q[n] <= '0;
                len_q[n]    <= '0;
            end
        end else begin
            oStart <= '0;
            oAbort <= '0;
            for (int unsigned n = 0; n < NUM_CH; n++) begin
                if (wr_sel[n]) begin
                    case (acc_reg)
                        REG_RDADDR:  if (state_q[n] == ST_IDLE) rdaddr_q[n] <= iWritedata;
                        REG_WRADDR:  if (state_q[n] == ST_IDLE) wraddr_q[n] <= iWritedata;
                        REG_LENGTH:  if (state_q[n] == ST_IDLE) len_q[n] <= iWritedata[LEN_W-1:0];
                        REG_CONTROL: ie_q[n] <= iWritedata[1];
                        REG_STATUS: begin
                            if (iWritedata[0]) done_q[n] <= 1'b0;
                            if (iWritedata[2]) err_q[n]  <= 1'b0;
                            if (iWritedata[3]) abt_q[n]  <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                // Event handling follows the W1C so a same-cycle hardware set wins
                case (state_q[n])
                    ST_IDLE: begin
                        if (wr_sel[n] && acc_reg == REG_CONTROL && iWritedata[0] && !iWritedata[2]) begin
                            if (len_q[n] != '0) begin
                                oStart[n]  <= 1'b1;
                                state_q[n] <= ST_BUSY;
                                done_q[n]  <= 1'b0;
                                err_q[n]   <= 1'b0;
                                abt_q[n]   <= 1'b0;
                            end else begin
                                done_q[n] <= 1'b1;
                            end
                        end
                    end
                    ST_BUSY: begin
                        if (iError[n]) begin
                            err_q[n]   <= 1'b1;
                            state_q[n] <= ST_IDLE;
                        end else if (iWM_done[n]) begin
                            done_q[n]  <= 1'b1;
                            state_q[n] <= ST_IDLE;
                        end else if (wr_sel[n] && acc_reg == REG_CONTROL && iWritedata[2]) begin
                            oAbort[n]  <= 1'b1;
                            abt_q[n]   <= 1'b1;
                            state_q[n] <= ST_IDLE;
                        end
                    end
                    default: state_q[n] <= ST_IDLE;
                endcase
            end
        end
    end

    // Registered read data and interrupt level
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            oReaddata <= '0;
            oIrq      <= 1'b0;
        end else begin
            oReaddata <= (iChipselect & iRead) ? rd_mux : '0;
            oIrq      <= |(ie_q & (done_q | err_q | abt_q));
        end
    end

endmodule

// File: tb/tb_dma_csr_multi.sv
// Self-checking bench: a 4-channel/24-bit and a 3-channel/16-bit instance share
// one Avalon bus; a transaction-level model predicts every output each cycle.
module tb_dma_csr_multi;

    logic        clk;
    logic        rst_n;
    logic        cs, rd, wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wm_done, err_in;

    logic [31:0]  rdata4, rdata3;
    logic         irq4, irq3;
    logic [127:0] rm4, wm4;
    logic [95:0]  rm3, wm3;
    logic [95:0]  len4;
    logic [47:0]  len3;
    logic [3:0]   start4, abort4;
    logic [2:0]   start3, abort3;

    int n_tests = 0;
    int n_fail  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dma_csr_multi #(.NUM_CH(4), .LEN_W(24)) dut4 (
        .iClk(clk), .iReset_n(rst_n), .iChipselect(cs), .iRead(rd), .iWrite(wr),
        .iAddress(addr), .iWritedata(wdata), .oReaddata(rdata4), .oIrq(irq4),
        .oRM_startaddress(rm4), .oWM_startaddress(wm4), .oLength(len4),
        .oStart(start4), .oAbort(abort4), .iWM_done(wm_done), .iError(err_in)
    );

    dma_csr_multi #(.NUM_CH(3), .LEN_W(16)) dut3 (
        .iClk(clk), .iReset_n(rst_n), .iChipselect(cs), .iRead(rd), .iWrite(wr),
        .iAddress(addr), .iWritedata(wdata), .oReaddata(rdata3), .oIrq(irq3),
        .oRM_startaddress(rm3), .oWM_startaddress(wm3), .oLength(len3),
        .oStart(start3), .oAbort(abort3), .iWM_done(wm_done[2:0]), .iError(err_in[2:0])
    );

    // Reference model state: index 0 = 4-channel instance, 1 = 3-channel instance
    logic [31:0] m_rd  [2][4];
    logic [31:0] m_wr  [2][4];
    logic [31:0] m_len [2][4];
    bit          m_ie  [2][4];
    bit          m_done[2][4];
    bit          m_busy[2][4];
    bit          m_err [2][4];
    bit          m_abt [2][4];
    bit          e_start[2][4];
    bit          e_abort[2][4];
    logic [31:0] e_rdata[2];
    bit          e_irq  [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int unsigned nch(input int m);
        return (m == 0) ? 4 : 3;
    endfunction

    function automatic logic [31:0] lmask(input int m);
        return (m == 0) ? 32'h00FF_FFFF : 32'h0000_FFFF;
    endfunction

    function automatic logic [31:0] o_rm(input int m, input int ch);
        if (m == 0) return rm4[ch*32 +: 32];
        else        return rm3[ch*32 +: 32];
    endfunction

    function automatic logic [31:0] o_wm(input int m, input int ch);
        if (m == 0) return wm4[ch*32 +: 32];
        else        return wm3[ch*32 +: 32];
    endfunction

    function automatic logic [31:0] o_len(input int m, input int ch);
        if (m == 0) return {8'h0, len4[ch*24 +: 24]};
        else        return {16'h0, len3[ch*16 +: 16]};
    endfunction

    function automatic logic o_start(input int m, input int ch);
        if (m == 0) return start4[ch];
        else        return start3[ch];
    endfunction

    function automatic logic o_abort(input int m, input int ch);
        if (m == 0) return abort4[ch];
        else        return abort3[ch];
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            e_rdata[m] = '0;
            e_irq[m]   = 1'b0;
            for (int ch = 0; ch < 4; ch++) begin
                m_rd[m][ch] = '0;  m_wr[m][ch] = '0;  m_len[m][ch] = '0;
                m_ie[m][ch] = 0;   m_done[m][ch] = 0; m_busy[m][ch] = 0;
                m_err[m][ch] = 0;  m_abt[m][ch] = 0;
                e_start[m][ch] = 0; e_abort[m][ch] = 0;
            end
        end
    endtask

    function automatic logic [31:0] model_read(input int m);
        int unsigned ach = addr[4:3];
        if (ach >= nch(m)) return '0;
        case (addr[2:0])
            3'd0:    return m_rd[m][ach];
            3'd1:    return m_wr[m][ach];
            3'd2:    return m_len[m][ach];
            3'd3:    return {30'h0, m_ie[m][ach], 1'b0};
            3'd4:    return {28'h0, m_abt[m][ach], m_err[m][ach], m_busy[m][ach], m_done[m][ach]};
            default: return '0;
        endcase
    endfunction

    // Advance the model by one clock using the currently driven inputs
    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            bit irq = 0;
            e_rdata[m] = (cs && rd) ? model_read(m) : 32'h0;
            for (int ch = 0; ch < int'(nch(m)); ch++)
                irq |= m_ie[m][ch] && (m_done[m][ch] || m_err[m][ch] || m_abt[m][ch]);
            e_irq[m] = irq;
            for (int ch = 0; ch < int'(nch(m)); ch++) begin
                bit hit      = cs && wr && (int'(addr[4:3]) == ch);
                bit go       = hit && addr[2:0] == 3'd3 && wdata[0] && !wdata[2];
                bit ab       = hit && addr[2:0] == 3'd3 && wdata[2];
                bit was_busy = m_busy[m][ch];
                e_start[m][ch] = 0;
                e_abort[m][ch] = 0;
                if (hit) begin
                    case (addr[2:0])
                        3'd0: if (!was_busy) m_rd[m][ch] = wdata;
                        3'd1: if (!was_busy) m_wr[m][ch] = wdata;
                        3'd2: if (!was_busy) m_len[m][ch] = wdata & lmask(m);
                        3'd3: m_ie[m][ch] = wdata[1];
                        3'd4: begin
                            if (wdata[0]) m_done[m][ch] = 0;
                            if (wdata[2]) m_err[m][ch]  = 0;
                            if (wdata[3]) m_abt[m][ch]  = 0;
                        end
                        default: ;
                    endcase
                end
                if (was_busy) begin
                    if (err_in[ch]) begin
                        m_err[m][ch] = 1; m_busy[m][ch] = 0;
                    end else if (wm_done[ch]) begin
                        m_done[m][ch] = 1; m_busy[m][ch] = 0;
                    end else if (ab) begin
                        m_abt[m][ch] = 1; m_busy[m][ch] = 0; e_abort[m][ch] = 1;
                    end
                end else if (go) begin
                    if (m_len[m][ch] != 0) begin
                        e_start[m][ch] = 1; m_busy[m][ch] = 1;
                        m_done[m][ch] = 0; m_err[m][ch] = 0; m_abt[m][ch] = 0;
                    end else begin
                        m_done[m][ch] = 1;
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("m0_rdata", rdata4, e_rdata[0]);
        check("m1_rdata", rdata3, e_rdata[1]);
        check("m0_irq", {31'h0, irq4}, {31'h0, e_irq[0]});
        check("m1_irq", {31'h0, irq3}, {31'h0, e_irq[1]});
        for (int m = 0; m < 2; m++) begin
            for (int ch = 0; ch < int'(nch(m)); ch++) begin
                check($sformatf("m%0d_ch%0d_start", m, ch), {31'h0, o_start(m, ch)}, {31'h0, e_start[m][ch]});
                check($sformatf("m%0d_ch%0d_abort", m, ch), {31'h0, o_abort(m, ch)}, {31'h0, e_abort[m][ch]});
                check($sformatf("m%0d_ch%0d_rdaddr", m, ch), o_rm(m, ch), m_rd[m][ch]);
                check($sformatf("m%0d_ch%0d_wraddr", m, ch), o_wm(m, ch), m_wr[m][ch]);
                check($sformatf("m%0d_ch%0d_length", m, ch), o_len(m, ch), m_len[m][ch]);
            end
        end
    endtask

    // One clock: predict, clock, sample 1 time unit after the edge, return bus to idle
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        compare_all();
        cs = 0; rd = 0; wr = 0; wm_done = '0; err_in = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        compare_all();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1; wr = 1; addr = a; wdata = d;
        step();
    endtask

    task automatic bus_read(input logic [4:0] a);
        cs = 1; rd = 1; addr = a;
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        cs = 0; rd = 0; wr = 0; addr = '0; wdata = '0; wm_done = '0; err_in = '0;
        #1;
        do_reset();
        check("reset_rdata", rdata4, 32'h0);
        step();

        // Channel 2 full transfer with interrupt
        bus_write(5'd16, 32'h1000);
        bus_write(5'd17, 32'h2000);
        bus_write(5'd18, 32'h40);
        bus_write(5'd19, 32'h3);
        check("c2_start_hi", {28'h0, start4}, 32'h4);
        check("c2_rdaddr", rm4[64 +: 32], 32'h1000);
        bus_read(5'd20);
        check("c2_start_lo", {28'h0, start4}, 32'h0);
        check("c2_status_busy", rdata4, 32'h2);
        wm_done = 4'b0100;
        step();
        bus_read(5'd20);
        check("c2_status_done", rdata4, 32'h1);
        check("c2_irq_hi", {31'h0, irq4}, 32'h1);
        bus_write(5'd20, 32'h1);
        step();
        check("c2_irq_lo", {31'h0, irq4}, 32'h0);

        // Channel 0 zero-length GO
        bus_write(5'd2, 32'h0);
        bus_write(5'd3, 32'h1);
        check("c0_nostart", {28'h0, start4}, 32'h0);
        bus_read(5'd4);
        check("c0_status_done", rdata4, 32'h1);

        // Channel 1 busy: programming locked, GO ignored, then abort
        bus_write(5'd10, 32'h10);
        bus_write(5'd11, 32'h1);
        check("c1_start", {28'h0, start4}, 32'h2);
        bus_write(5'd10, 32'h99);
        check("c1_len_locked", {8'h0, len4[24 +: 24]}, 32'h10);
        bus_write(5'd11, 32'h1);
        check("c1_no_restart", {28'h0, start4}, 32'h0);
        bus_write(5'd11, 32'h4);
        check("c1_abort_hi", {28'h0, abort4}, 32'h2);
        bus_read(5'd12);
        check("c1_abort_lo", {28'h0, abort4}, 32'h0);
        check("c1_status_aborted", rdata4, 32'h8);

        // Channel 3 error beats done and a concurrent W1C; absent on the 3-channel part
        bus_write(5'd26, 32'h5);
        bus_write(5'd27, 32'h1);
        check("c3_start", {28'h0, start4}, 32'h8);
        check("c3_absent_start", {29'h0, start3}, 32'h0);
        wm_done = 4'b1000; err_in = 4'b1000;
        bus_write(5'd28, 32'h4);
        bus_read(5'd28);
        check("c3_status_err", rdata4, 32'h4);
        check("c3_absent_read", rdata3, 32'h0);

        // Reset while channel 0 is busy, then restart
        bus_write(5'd2, 32'h8);
        bus_write(5'd3, 32'h1);
        step();
        do_reset();
        check("rst_no_abort", {28'h0, abort4}, 32'h0);
        step();
        check("rst_after_abort", {28'h0, abort4}, 32'h0);
        bus_write(5'd2, 32'h8);
        bus_write(5'd3, 32'h1);
        check("rst_restart", {28'h0, start4}, 32'h1);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            int unsigned r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset();
            end else begin
                for (int ch = 0; ch < 4; ch++) begin
                    wm_done[ch] = ($urandom_range(0, 7) == 0);
                    err_in[ch]  = ($urandom_range(0, 15) == 0);
                end
                addr = 5'($urandom_range(0, 31));
                if (r < 80) begin
                    bus_read(addr);
                end else if (r < 170) begin
                    case (addr[2:0])
                        3'd2:    wdata = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
                        3'd3:    wdata = 32'($urandom_range(0, 7));
                        3'd4:    wdata = 32'($urandom_range(0, 15));
                        default: wdata = $urandom;
                    endcase
                    bus_write(addr, wdata);
                end else begin
                    step();
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
